// File: rtl/ha_pkg.sv
// ha_pkg: shared defaults, FSM state and word record for the half-adder stream packer
package ha_pkg;
  localparam int BEAT_W_D = 8;
  localparam int CNT_W_D = 4;
  typedef enum logic {FILL, HOLD} state_t;
  typedef struct packed {
    logic [BEAT_W_D-1:0] data;
    logic [CNT_W_D-1:0] len;
    logic [CNT_W_D-1:0] carries;
  } word_t;
endpackage

// File: rtl/ha_stream_packer.sv
// ha_stream_packer: packs sum bits LSB-first into words, counts carries, single-entry valid/ready output
module ha_stream_packer
  import ha_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sum,
  input  logic              in_carry,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_len,
  output logic [CNT_W-1:0]  out_carries,
  output logic [7:0]        word_count
);
  state_t state, nstate;
  logic [CNT_W-1:0] fill_cnt, carry_cnt, nfill, ncarry;
  logic [BEAT_W-1:0] shift_reg, nshift;
  logic acc, done, xfer;
  always_comb begin
    acc = in_valid && state == FILL;
    nfill = fill_cnt + CNT_W'(acc);
    ncarry = carry_cnt + CNT_W'(acc && in_carry);
    nshift = shift_reg | (BEAT_W'(acc && in_sum) << fill_cnt);
    // flush coinciding with the completing beat is absorbed by the full word
    done = state == FILL && (nfill == CNT_W'(BEAT_W) || (flush && nfill != '0));
    xfer = state == HOLD && out_ready;
    nstate = done ? HOLD : xfer ? FILL : state;
  end
  assign in_ready = state == FILL;
  assign out_valid = state == HOLD;
  always_ff @(posedge clk)
    state <= rst ? FILL : nstate;
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      carry_cnt <= '0;
      shift_reg <= '0;
      out_data <= '0;
      out_len <= '0;
      out_carries <= '0;
      word_count <= '0;
    end else begin
      if (done) begin
        out_data <= nshift;
        out_len <= nfill;
        out_carries <= ncarry;
        fill_cnt <= '0;
        carry_cnt <= '0;
        shift_reg <= '0;
      end else if (acc) begin
        fill_cnt <= nfill;
        carry_cnt <= ncarry;
        shift_reg <= nshift;
      end
      if (xfer) word_count <= word_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_ha_stream_packer.sv
// tb_ha_stream_packer: directed vector table plus hand sequences for backpressure, reset and wrap
module tb_ha_stream_packer;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_sum = 0, in_carry = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] out_data, word_count;
  logic [3:0] out_len, out_carries;
  int checks = 0, failures = 0;

  typedef struct {
    logic iv, s, c, f, r;
    logic ov, ir;
    logic [7:0] d;
    logic [3:0] l, k;
    logic [7:0] w;
  } vec_t;
  vec_t q[$];

  ha_stream_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_carries(out_carries), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic chk_all(input string n, input logic ov, input logic ir, input logic [7:0] d,
                         input logic [3:0] l, input logic [3:0] k, input logic [7:0] w);
    chk({n, ".out_valid"}, int'(out_valid), int'(ov));
    chk({n, ".in_ready"}, int'(in_ready), int'(ir));
    chk({n, ".out_data"}, int'(out_data), int'(d));
    chk({n, ".out_len"}, int'(out_len), int'(l));
    chk({n, ".out_carries"}, int'(out_carries), int'(k));
    chk({n, ".word_count"}, int'(word_count), int'(w));
  endtask

  task automatic step(input logic iv, input logic s, input logic c, input logic f, input logic r);
    in_valid = iv; in_sum = s; in_carry = c; flush = f; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic s, input logic c, input logic f, input logic r,
                     input logic ov, input logic ir, input logic [7:0] d,
                     input logic [3:0] l, input logic [3:0] k, input logic [7:0] w);
    q.push_back('{iv, s, c, f, r, ov, ir, d, l, k, w});
  endtask

  initial begin
    int bad;
    // full word 0x4D, then transfer
    add(1,1,0,0,1, 0,1,8'h00,0,0,0);
    add(1,0,1,0,1, 0,1,8'h00,0,0,0);
    add(1,1,0,0,1, 0,1,8'h00,0,0,0);
    add(1,1,0,0,1, 0,1,8'h00,0,0,0);
    add(1,0,1,0,1, 0,1,8'h00,0,0,0);
    add(1,0,1,0,1, 0,1,8'h00,0,0,0);
    add(1,1,0,0,1, 0,1,8'h00,0,0,0);
    add(1,0,1,0,1, 1,0,8'h4D,8,4,0);
    add(0,0,0,0,1, 0,1,8'h4D,8,4,1);
    // partial flush of 3 bits, then empty flush
    add(1,1,1,0,0, 0,1,8'h4D,8,4,1);
    add(1,1,0,0,0, 0,1,8'h4D,8,4,1);
    add(1,1,1,0,0, 0,1,8'h4D,8,4,1);
    add(0,0,0,1,0, 1,0,8'h07,3,2,1);
    add(0,0,0,0,1, 0,1,8'h07,3,2,2);
    add(0,0,0,1,1, 0,1,8'h07,3,2,2);
    add(0,0,0,0,1, 0,1,8'h07,3,2,2);
    // flush together with beat 5
    add(1,1,0,0,1, 0,1,8'h07,3,2,2);
    add(1,0,0,0,1, 0,1,8'h07,3,2,2);
    add(1,1,0,0,1, 0,1,8'h07,3,2,2);
    add(1,0,0,0,1, 0,1,8'h07,3,2,2);
    add(1,1,1,1,0, 1,0,8'h15,5,1,2);
    add(0,0,0,0,1, 0,1,8'h15,5,1,3);
    // flush together with beat 8, flush in HOLD not queued
    for (int i = 0; i < 7; i++) add(1,0,1,0,1, 0,1,8'h15,5,1,3);
    add(1,1,0,1,0, 1,0,8'h80,8,7,3);
    add(0,0,0,1,1, 0,1,8'h80,8,7,4);
    add(0,0,0,0,1, 0,1,8'h80,8,7,4);

    step(0,0,0,0,0);
    step(0,0,0,0,0);
    rst = 0;
    chk_all("reset", 0, 1, 8'h00, 0, 0, 0);
    foreach (q[i]) begin
      step(q[i].iv, q[i].s, q[i].c, q[i].f, q[i].r);
      chk_all($sformatf("vec%0d", i), q[i].ov, q[i].ir, q[i].d, q[i].l, q[i].k, q[i].w);
    end

    // backpressure: word 0x33 held for 5 cycles while extra beats are offered
    for (int i = 0; i < 8; i++) step(1, (i % 4) < 2, 0, 0, 0);
    chk_all("bp_full", 1, 0, 8'h33, 8, 0, 4);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0, 0);
      chk_all($sformatf("bp_hold%0d", i), 1, 0, 8'h33, 8, 0, 4);
    end
    step(0, 0, 0, 0, 1);
    chk_all("bp_release", 0, 1, 8'h33, 8, 0, 5);
    step(0, 0, 0, 1, 1);
    chk_all("bp_no_extra", 0, 1, 8'h33, 8, 0, 5);

    // reset mid-word discards the 4 stale bits
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1);
    rst = 1;
    step(1, 1, 1, 1, 1);
    rst = 0;
    chk_all("mid_reset", 0, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);
    chk("rst_fill7.out_valid", int'(out_valid), 0);
    step(1, 1, 0, 0, 0);
    chk_all("rst_word", 1, 0, 8'hFF, 8, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_wc", int'(word_count), 1);

    // 255 more words -> 256 transfers total wraps to 0, then 257th gives 1
    bad = 0;
    for (int n = 0; n < 255; n++) begin
      for (int i = 0; i < 8; i++) step(1, n[0], 0, 0, 1);
      if (!out_valid) bad++;
      step(0, 0, 0, 0, 1);
    end
    chk("wrap_ov_misses", bad, 0);
    chk("wrap_wc0", int'(word_count), 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_wc1", int'(word_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
